// File: rtl/fifo_defs.sv
// Shared defaults for the FIFO pointer/flag controller.
//   RAM_DEPTH : entries in the dual-port RAM (2**PTR_SIZE)
//   PTR_SIZE  : RAM address width
//   AF_THR    : almost_full when count >= AF_THR
//   AE_THR    : almost_empty when count <= AE_THR
//   CNT_W     : occupancy width, one bit wider than a pointer so that
//               a completely full RAM is representable
package fifo_defs;

  localparam int RAM_DEPTH = 8;
  localparam int PTR_SIZE  = 3;
  localparam int AF_THR    = 6;
  localparam int AE_THR    = 2;
  localparam int CNT_W     = PTR_SIZE + 1;

endpackage

// File: rtl/ptr_counter.sv
// Wrapping RAM address counter with enable.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears ptr to 0
//   en   : advance ptr by one on this edge
//   ptr  : current address; wraps RAM_DEPTH-1 -> 0 by natural overflow
module ptr_counter #(
  parameter int PTR_SIZE = fifo_defs::PTR_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [PTR_SIZE-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a dual-port RAM FIFO buffer.
// Converts producer push / consumer pop requests into RAM write/read
// strobes and addresses, tracks occupancy, and qualifies RAM read data.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   push, pop        : producer write / consumer read requests
//   wr_enb, rd_enb   : accepted push / pop (combinational, same cycle)
//   wr_ptr, rd_ptr   : RAM write / read addresses
//   count            : occupancy 0..RAM_DEPTH
//   full, empty      : count == RAM_DEPTH / count == 0
//   almost_full      : count >= AF_THR
//   almost_empty     : count <= AE_THR
//   data_valid       : RAM data_out valid (one cycle after rd_enb)
//   overflow         : sticky, push rejected while full
//   underflow        : sticky, pop rejected while empty
module fifo_ctrl #(
  parameter int RAM_DEPTH = fifo_defs::RAM_DEPTH,
  parameter int PTR_SIZE  = fifo_defs::PTR_SIZE,
  parameter int AF_THR    = fifo_defs::AF_THR,
  parameter int AE_THR    = fifo_defs::AE_THR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  output logic                wr_enb,
  output logic                rd_enb,
  output logic [PTR_SIZE-1:0] wr_ptr,
  output logic [PTR_SIZE-1:0] rd_ptr,
  output logic [PTR_SIZE:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                data_valid,
  output logic                overflow,
  output logic                underflow
);

  localparam int CNT_W = PTR_SIZE + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THR);

  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;
  logic             ovf_p1;
  logic             unf_p1;

  // A push into a full RAM is safe when a pop frees the same slot on the
  // same edge: the RAM reads the old word before the write lands.
  // A pop from empty is never accepted, even with a concurrent push.
  assign wr_enb = push & (~full | pop);
  assign rd_enb = pop & ~empty;

  ptr_counter #(.PTR_SIZE(PTR_SIZE)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_enb),
    .ptr (wr_ptr)
  );

  ptr_counter #(.PTR_SIZE(PTR_SIZE)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_enb),
    .ptr (rd_ptr)
  );

  // ---- stage p1: occupancy, read-data qualifier, sticky errors ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p1 <= '0;
      vld_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      if (wr_enb && !rd_enb) begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end else if (rd_enb && !wr_enb) begin
        cnt_p1 <= cnt_p1 - 1'b1;
      end
      vld_p1 <= rd_enb;
      if (push && full && !pop) begin
        ovf_p1 <= 1'b1;
      end
      if (pop && empty) begin
        unf_p1 <= 1'b1;
      end
    end
  end

  // Flags decode the registered count only, so push/pop never reach them
  // combinationally.
  assign count        = cnt_p1;
  assign full         = (cnt_p1 == DEPTH_C);
  assign empty        = (cnt_p1 == '0);
  assign almost_full  = (cnt_p1 >= AF_C);
  assign almost_empty = (cnt_p1 <= AE_C);
  assign data_valid   = vld_p1;
  assign overflow     = ovf_p1;
  assign underflow    = unf_p1;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic       wr_enb;
  logic       rd_enb;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       data_valid;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .wr_enb       (wr_enb),
    .rd_enb       (rd_enb),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request cycle and advance past the edge.
  task automatic op(input logic p, input logic q);
    push = p;
    pop  = q;
    tick();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;

    // Reset held
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_dv", data_valid, 0);

    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_count", count, 0);
    chk("idle_empty", empty, 1);
    chk("idle_wr_ptr", wr_ptr, 0);
    chk("idle_rd_ptr", rd_ptr, 0);
    chk("idle_dv", data_valid, 0);
    chk("idle_ovf", overflow, 0);
    chk("idle_unf", underflow, 0);

    // Fill with 8 pushes
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      #1;
      chk("fill_wr_enb", wr_enb, 1);
      chk("fill_wr_ptr", wr_ptr, i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 6);
      chk("fill_full", full, (i + 1) == 8);
    end
    push = 1'b0;
    chk("fill_wrap", wr_ptr, 0);
    chk("fill_empty", empty, 0);

    // Push while full, no pop: rejected
    push = 1'b1;
    #1;
    chk("ovf_wr_enb", wr_enb, 0);
    tick();
    push = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_wr_ptr", wr_ptr, 0);

    // Drain with 8 pops
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      #1;
      chk("drain_rd_enb", rd_enb, 1);
      chk("drain_rd_ptr", rd_ptr, i);
      chk("drain_dv", data_valid, i > 0);
      tick();
      chk("drain_count", count, 7 - i);
    end
    pop = 1'b0;
    #1;
    chk("drain_dv_last", data_valid, 1);
    chk("drain_wrap", rd_ptr, 0);
    chk("drain_empty", empty, 1);

    // Pop while empty: rejected
    pop = 1'b1;
    #1;
    chk("unf_rd_enb", rd_enb, 0);
    tick();
    pop = 1'b0;
    chk("unf_flag", underflow, 1);
    chk("unf_dv", data_valid, 0);
    chk("unf_count", count, 0);

    // Push+pop at empty: only push accepted
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("sim0_wr_enb", wr_enb, 1);
    chk("sim0_rd_enb", rd_enb, 0);
    tick();
    push = 1'b0;
    pop  = 1'b0;
    chk("sim0_count", count, 1);
    chk("sim0_dv", data_valid, 0);
    chk("sim0_wr_ptr", wr_ptr, 1);
    chk("sim0_rd_ptr", rd_ptr, 0);

    op(1'b1, 1'b0);
    op(1'b1, 1'b0);
    chk("pre3_count", count, 3);

    // Push+pop at count 3
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("sim3_wr_enb", wr_enb, 1);
    chk("sim3_rd_enb", rd_enb, 1);
    tick();
    push = 1'b0;
    pop  = 1'b0;
    chk("sim3_count", count, 3);
    chk("sim3_wr_ptr", wr_ptr, 4);
    chk("sim3_rd_ptr", rd_ptr, 1);
    chk("sim3_dv", data_valid, 1);

    // almost_full edge 5 -> 6 -> 5
    op(1'b1, 1'b0);
    op(1'b1, 1'b0);
    chk("af5_count", count, 5);
    chk("af5_flag", almost_full, 0);
    push = 1'b1;
    #1;
    chk("af5_hold", almost_full, 0);
    tick();
    push = 1'b0;
    chk("af6_flag", almost_full, 1);
    op(1'b0, 1'b1);
    chk("af5b_flag", almost_full, 0);

    // almost_empty edge 3 -> 2 -> 3
    op(1'b0, 1'b1);
    op(1'b0, 1'b1);
    chk("ae3_count", count, 3);
    chk("ae3_flag", almost_empty, 0);
    pop = 1'b1;
    #1;
    chk("ae3_hold", almost_empty, 0);
    tick();
    pop = 1'b0;
    chk("ae2_flag", almost_empty, 1);
    op(1'b1, 1'b0);
    chk("ae3b_flag", almost_empty, 0);
    chk("ae_wr_ptr", wr_ptr, 0);
    chk("ae_rd_ptr", rd_ptr, 5);

    // Fill to 8 then push+pop at full
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0);
    chk("full8_flag", full, 1);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("simf_wr_enb", wr_enb, 1);
    chk("simf_rd_enb", rd_enb, 1);
    tick();
    push = 1'b0;
    pop  = 1'b0;
    chk("simf_count", count, 8);
    chk("simf_full", full, 1);
    chk("simf_wr_ptr", wr_ptr, 6);
    chk("simf_rd_ptr", rd_ptr, 6);
    chk("simf_ovf", overflow, 1);
    chk("simf_unf", underflow, 1);

    // Down to 4 then asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1);
    chk("mid_count", count, 4);
    chk("mid_rd_ptr", rd_ptr, 2);
    push = 1'b1;
    tick();
    chk("mid_count5", count, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_wr_ptr", wr_ptr, 0);
    chk("arst_rd_ptr", rd_ptr, 0);
    chk("arst_empty", empty, 1);
    chk("arst_aempty", almost_empty, 1);
    chk("arst_full", full, 0);
    chk("arst_afull", almost_full, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_unf", underflow, 0);
    chk("arst_dv", data_valid, 0);
    tick();
    chk("arst_hold_wr_ptr", wr_ptr, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_wr_enb", wr_enb, 1);
    chk("rel_wr_ptr", wr_ptr, 0);
    tick();
    push = 1'b0;
    chk("rel_wr_ptr_after", wr_ptr, 1);
    chk("rel_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
